// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, instruction memory, IF/ID register and the run/halt FSM.
// Memory is loaded while idle or halted; fetching stops when the halt word is reached.
module if_stage #(
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned ADDR_W    = 8,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic              ClockIn,
  input  logic              Reset,
  input  logic              Start,
  input  logic              LoadEn,
  input  logic [ADDR_W-1:0] LoadAddr,
  input  logic [31:0]       LoadData,
  input  logic              Stall,
  input  logic              Flush,
  input  logic              PCSrc,
  input  logic [31:0]       BranchTarget,
  output logic [31:0]       PC,
  output logic [31:0]       Out_Instruction,
  output logic [31:0]       Out_PCPlus4,
  output logic              Out_Valid,
  output logic              Halted
);

  typedef enum logic [1:0] {StIdle, StRun, StHalted} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic        halted_q, halted_d;

  logic [31:0]       mem_q [MEM_DEPTH];
  logic [ADDR_W-1:0] fetch_idx;
  logic [31:0]       fetch_word;
  logic [31:0]       pc_plus4;
  logic              advance;
  logic              fetch_is_halt;
  logic              load_ok;

  // PC[1:0] and bits above the memory index are ignored, so fetches wrap.
  assign fetch_idx     = pc_q[ADDR_W+1:2];
  assign fetch_word    = mem_q[fetch_idx];
  assign pc_plus4      = pc_q + 32'd4;
  assign advance       = (state_q == StRun) && !Stall;
  assign fetch_is_halt = (fetch_word == HALT_WORD);
  assign load_ok       = LoadEn && (state_q != StRun);

  // Contents survive reset; only the loader changes them.
  always_ff @(posedge ClockIn) begin
    if (load_ok) begin
      mem_q[LoadAddr] <= LoadData;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      StIdle, StHalted: begin
        if (Start) begin
          state_d = StRun;
          pc_d    = 32'd0;
        end
      end
      StRun: begin
        if (!Stall) begin
          if (PCSrc) begin
            pc_d = BranchTarget;
          end else if (fetch_is_halt) begin
            state_d = StHalted;
          end else begin
            pc_d = pc_plus4;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    halted_d = (state_d == StHalted);
  end

  // A fetched halt word never enters IF/ID, even when a redirect overrides the halt.
  always_comb begin
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (Flush) begin
      instr_d = 32'd0;
      pc4_d   = 32'd0;
      valid_d = 1'b0;
    end else if (Stall) begin
      instr_d = instr_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
    end else if (advance && !fetch_is_halt) begin
      instr_d = fetch_word;
      pc4_d   = pc_plus4;
      valid_d = 1'b1;
    end else begin
      instr_d = 32'd0;
      pc4_d   = 32'd0;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge ClockIn or negedge Reset) begin
    if (!Reset) begin
      state_q  <= StIdle;
      pc_q     <= 32'd0;
      instr_q  <= 32'd0;
      pc4_q    <= 32'd0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc4_q    <= pc4_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

  assign PC              = pc_q;
  assign Out_Instruction = instr_q;
  assign Out_PCPlus4     = pc4_q;
  assign Out_Valid       = valid_q;
  assign Halted          = halted_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: expected outputs are queued as each step is driven
// and compared just after the following clock edge.
module tb_if_stage;

  localparam logic [31:0] I0   = 32'h2001_0005;
  localparam logic [31:0] I1   = 32'h2002_0003;
  localparam logic [31:0] I2   = 32'h2003_0007;
  localparam logic [31:0] I3   = 32'h2005_000B;
  localparam logic [31:0] I4   = 32'h2004_0009;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, load_en, stall, flush, pcsrc;
  logic [7:0]  load_addr;
  logic [31:0] load_data, target;
  logic [31:0] pc, ins, p4;
  logic        valid, halted;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic [31:0] ins;
    logic [31:0] p4;
    logic        v;
    logic        h;
  } exp_t;

  exp_t sb[$];

  if_stage #(
    .MEM_DEPTH(256),
    .ADDR_W   (8),
    .HALT_WORD(32'hFFFF_FFFF)
  ) dut (
    .ClockIn        (clk),
    .Reset          (rst_n),
    .Start          (start),
    .LoadEn         (load_en),
    .LoadAddr       (load_addr),
    .LoadData       (load_data),
    .Stall          (stall),
    .Flush          (flush),
    .PCSrc          (pcsrc),
    .BranchTarget   (target),
    .PC             (pc),
    .Out_Instruction(ins),
    .Out_PCPlus4    (p4),
    .Out_Valid      (valid),
    .Halted         (halted)
  );

  always #5 clk = ~clk;

  task automatic expect_now(input string tag, input logic [31:0] epc, input logic [31:0] ei,
                            input logic [31:0] ep4, input logic ev, input logic eh);
    exp_t e;
    e.tag = tag;
    e.pc  = epc;
    e.ins = ei;
    e.p4  = ep4;
    e.v   = ev;
    e.h   = eh;
    sb.push_back(e);
  endtask

  task automatic check_now();
    exp_t e;
    e = sb.pop_front();
    checks++;
    assert (pc === e.pc) else begin
      failures++;
      $error("FAIL %s pc got=%h exp=%h", e.tag, pc, e.pc);
    end
    checks++;
    assert (ins === e.ins) else begin
      failures++;
      $error("FAIL %s instr got=%h exp=%h", e.tag, ins, e.ins);
    end
    checks++;
    assert (p4 === e.p4) else begin
      failures++;
      $error("FAIL %s pcplus4 got=%h exp=%h", e.tag, p4, e.p4);
    end
    checks++;
    assert (valid === e.v) else begin
      failures++;
      $error("FAIL %s valid got=%b exp=%b", e.tag, valid, e.v);
    end
    checks++;
    assert (halted === e.h) else begin
      failures++;
      $error("FAIL %s halted got=%b exp=%b", e.tag, halted, e.h);
    end
  endtask

  // Queue the expectation for the coming edge, then compare just after it.
  task automatic step(input string tag, input logic [31:0] epc, input logic [31:0] ei,
                      input logic [31:0] ep4, input logic ev, input logic eh);
    expect_now(tag, epc, ei, ep4, ev, eh);
    @(posedge clk);
    #1;
    check_now();
  endtask

  task automatic load(input logic [7:0] addr, input logic [31:0] data);
    load_en   = 1'b1;
    load_addr = addr;
    load_data = data;
    @(posedge clk);
    #1;
    load_en = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    load_en   = 1'b0;
    stall     = 1'b0;
    flush     = 1'b0;
    pcsrc     = 1'b0;
    load_addr = 8'd0;
    load_data = 32'd0;
    target    = 32'd0;

    #2;
    expect_now("reset", 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    check_now();
    rst_n = 1'b1;
    step("idle", 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);

    // Basic program: two instructions then halt.
    load(8'd0, I0);
    load(8'd1, I1);
    load(8'd2, HALT);
    start = 1'b1;
    step("t1_start", 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    start = 1'b0;
    step("t1_i0", 32'd4, I0, 32'd4, 1'b1, 1'b0);
    step("t1_i1", 32'd8, I1, 32'd8, 1'b1, 1'b0);
    step("t1_halt", 32'd8, 32'd0, 32'd0, 1'b0, 1'b1);
    step("t1_hold", 32'd8, 32'd0, 32'd0, 1'b0, 1'b1);

    // Stall at PC=4, then stall while sitting on the halt word.
    start = 1'b1;
    step("t2_start", 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    start = 1'b0;
    step("t2_i0", 32'd4, I0, 32'd4, 1'b1, 1'b0);
    stall = 1'b1;
    step("t2_stall_a", 32'd4, I0, 32'd4, 1'b1, 1'b0);
    step("t2_stall_b", 32'd4, I0, 32'd4, 1'b1, 1'b0);
    stall = 1'b0;
    step("t2_i1", 32'd8, I1, 32'd8, 1'b1, 1'b0);
    stall = 1'b1;
    step("t2_stall_halt", 32'd8, I1, 32'd8, 1'b1, 1'b0);
    stall = 1'b0;
    step("t2_halt", 32'd8, 32'd0, 32'd0, 1'b0, 1'b1);

    // Redirect with flush at PC=8; write on the same edge as Start from HALTED.
    load(8'd2, I2);
    load(8'd4, I4);
    load_en   = 1'b1;
    load_addr = 8'd5;
    load_data = HALT;
    start     = 1'b1;
    step("t3_start", 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    load_en = 1'b0;
    start   = 1'b0;
    step("t3_i0", 32'd4, I0, 32'd4, 1'b1, 1'b0);
    step("t3_i1", 32'd8, I1, 32'd8, 1'b1, 1'b0);
    pcsrc  = 1'b1;
    target = 32'h10;
    flush  = 1'b1;
    step("t3_redirect", 32'h10, 32'd0, 32'd0, 1'b0, 1'b0);
    pcsrc = 1'b0;
    flush = 1'b0;
    step("t3_i4", 32'h14, I4, 32'h14, 1'b1, 1'b0);
    stall = 1'b1;
    flush = 1'b1;
    step("t3_flush_stall", 32'h14, 32'd0, 32'd0, 1'b0, 1'b0);
    stall = 1'b0;
    flush = 1'b0;
    step("t3_halt", 32'h14, 32'd0, 32'd0, 1'b0, 1'b1);

    // Halt word at PC=4 overridden by a redirect to 0.
    load(8'd1, HALT);
    start = 1'b1;
    step("t4_start", 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    start = 1'b0;
    step("t4_i0", 32'd4, I0, 32'd4, 1'b1, 1'b0);
    pcsrc  = 1'b1;
    target = 32'd0;
    flush  = 1'b1;
    step("t4_redirect", 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    pcsrc = 1'b0;
    flush = 1'b0;
    step("t4_i0b", 32'd4, I0, 32'd4, 1'b1, 1'b0);
    step("t4_halt", 32'd4, 32'd0, 32'd0, 1'b0, 1'b1);

    // Writes attempted during RUN must be dropped.
    start = 1'b1;
    step("t5_start", 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    start     = 1'b0;
    load_en   = 1'b1;
    load_addr = 8'd0;
    load_data = 32'hDEAD_BEEF;
    step("t5_i0", 32'd4, I0, 32'd4, 1'b1, 1'b0);
    step("t5_halt", 32'd4, 32'd0, 32'd0, 1'b0, 1'b1);
    load_en = 1'b0;
    start   = 1'b1;
    step("t5_start2", 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    start = 1'b0;
    step("t5_orig", 32'd4, I0, 32'd4, 1'b1, 1'b0);
    step("t5_halt2", 32'd4, 32'd0, 32'd0, 1'b0, 1'b1);

    // Asynchronous reset mid-run at PC=0x0C.
    load(8'd1, I1);
    load(8'd2, I2);
    load(8'd3, I3);
    start = 1'b1;
    step("t6_start", 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    start = 1'b0;
    step("t6_i0", 32'd4, I0, 32'd4, 1'b1, 1'b0);
    step("t6_i1", 32'd8, I1, 32'd8, 1'b1, 1'b0);
    step("t6_i2", 32'h0C, I2, 32'h0C, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    expect_now("t6_reset", 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    check_now();
    #2;
    rst_n = 1'b1;
    step("t6_idle", 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    start = 1'b1;
    step("t6_start2", 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    start = 1'b0;
    step("t6_r0", 32'd4, I0, 32'd4, 1'b1, 1'b0);
    step("t6_r1", 32'd8, I1, 32'd8, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
